// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream valid/ready/data, downstream
// valid/ready/data, synchronous flush and the stall-counter observation port.
// master: the environment around the stage; slave: the stage itself.
interface pipe_skid_stage_if #(
  parameter int DW   = 32,
  parameter int CNTW = 16
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [DW-1:0]   in_data_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [DW-1:0]   out_data_o;
  logic [CNTW-1:0] stall_cnt_o;

  modport master (
    output flush_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, stall_cnt_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry elastic pipeline register (main + skid) with a
// valid/ready handshake on both sides. in_ready_o, out_valid_o and out_data_o
// are taken straight from registers, so no input reaches an output through
// combinational logic. The skid entry catches the beat that was already in
// flight when downstream stalls; flush_i empties the stage synchronously.
//
// Optional feature: define PIPE_SKID_STALL_CNT_EN to build a saturating
// downstream-stall cycle counter on stall_cnt_o; otherwise stall_cnt_o is 0.
module pipe_skid_stage #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_skid_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [DW-1:0]   main_r;
  logic [DW-1:0]   skid_r;
  logic [DW-1:0]   main_d_s;
  logic            load_main_s;
  logic            load_skid_s;
  logic            main_from_skid_s;
  logic            in_ready_s;
  logic            out_valid_s;
  logic            in_fire_s;
  logic            out_fire_s;

  // Handshake qualifiers derived only from the state register.
  assign in_ready_s  = (state_r != FULL);
  assign out_valid_s = (state_r != EMPTY);
  assign in_fire_s   = bus.in_valid_i & in_ready_s;
  assign out_fire_s  = out_valid_s & bus.out_ready_i;

  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = out_valid_s;
  assign bus.out_data_o  = main_r;

  // Next-state and data-register enables; flush overrides every transition.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    main_from_skid_s = 1'b0;
    if (bus.flush_i) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = BUSY;
            load_main_s = 1'b1;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        BUSY: begin
          if (in_fire_s && out_fire_s) begin
            state_nxt_s = BUSY;
            load_main_s = 1'b1;
          end else if (in_fire_s) begin
            state_nxt_s = FULL;
            load_skid_s = 1'b1;
          end else if (out_fire_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = BUSY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire_s) begin
            state_nxt_s      = BUSY;
            load_main_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // Main register is refilled either from upstream or by promoting the skid entry.
  assign main_d_s = main_from_skid_s ? skid_r : bus.in_data_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Main data register, clock-enabled by load_main_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= {DW{1'b0}};
    end else if (load_main_s) begin
      main_r <= main_d_s;
    end
  end

  // Skid data register, clock-enabled by load_skid_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_r <= {DW{1'b0}};
    end else if (load_skid_s) begin
      skid_r <= bus.in_data_i;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CNTW-1:0] stall_cnt_r;
  logic            stall_s;

  assign stall_s = out_valid_s & ~bus.out_ready_i;

  // Saturating stall counter; only rst_n clears it, flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNTW{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNTW{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.stall_cnt_o = stall_cnt_r;
`else
  assign bus.stall_cnt_o = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: a table of directed vectors,
// hand-written sequences for async reset and the stall counter, and a
// random valid/ready run against a queue model.
module tb_pipe_skid_stage;

  localparam int DW   = 32;
  localparam int CNTW = 4;
`ifdef PIPE_SKID_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  pipe_skid_stage_if #(.DW(DW), .CNTW(CNTW)) bus ();

  pipe_skid_stage #(.DW(DW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          flush;
    logic          exp_valid;
    logic          exp_ready;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl,
                      input logic ev, input logic er, input logic [DW-1:0] ed);
    vec_t v;
    v.in_valid = iv; v.in_data = d; v.out_ready = ordy; v.flush = fl;
    v.exp_valid = ev; v.exp_ready = er; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    bus.in_valid_i  = iv;
    bus.in_data_i   = d;
    bus.out_ready_i = ordy;
    bus.flush_i     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] q[$];
  logic          r_iv;
  logic          r_or;
  logic          r_fl;
  logic [DW-1:0] r_d;
  logic          in_f;
  logic          out_f;
  logic [CNTW-1:0] exp_cnt;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #20;
    chk("reset_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("reset_in_ready",  {31'd0, bus.in_ready_o},  32'd1);
    chk("reset_out_data",  bus.out_data_o,           32'd0);
    chk("reset_stall_cnt", {28'd0, bus.stall_cnt_o}, 32'd0);
    #1 rst_n = 1'b1;
    step();

    // Streaming 1..8 with downstream always ready, then drain.
    for (int i = 1; i <= 8; i++) addv(1'b1, i, 1'b1, 1'b0, 1'b1, 1'b1, i);
    addv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    // Backpressure: A, B captured into skid, C held upstream until room.
    addv(1'b1, 32'hA, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA);
    addv(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA);
    addv(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA);
    addv(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB);
    addv(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB);
    addv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC);
    addv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    // Flush while FULL with a beat offered; 0x55 is the next output.
    addv(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11);
    addv(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11);
    addv(1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    addv(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55);
    addv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    // Flush in BUSY with both handshakes: incoming 0x77 is dropped.
    addv(1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 1'b1, 32'h66);
    addv(1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    addv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].flush);
      step();
      chk($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid_o}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_in_ready", i),  {31'd0, bus.in_ready_o},  {31'd0, vecs[i].exp_ready});
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_out_data", i), bus.out_data_o, vecs[i].exp_data);
      else                   chk($sformatf("vec%0d_empty", i), {31'd0, bus.out_valid_o}, 32'd0);
    end

    // Async reset while FULL, asserted between clock edges.
    drive(1'b1, 32'h91, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h92, 1'b0, 1'b0);
    step();
    chk("full_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
    chk("full_out_data", bus.out_data_o, 32'h91);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
    chk("arst_in_ready",  {31'd0, bus.in_ready_o},  32'd1);
    chk("arst_out_data",  bus.out_data_o,           32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    step();
    chk("post_arst_valid", {31'd0, bus.out_valid_o}, 32'd0);

    // Stall counter: after edge k of a held stall the count is k-1, saturating at 15.
    drive(1'b1, 32'hC0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 6) begin
        exp_cnt = CNT_EN ? 4'd5 : 4'd0;
        chk("stall_cnt_5", {28'd0, bus.stall_cnt_o}, {28'd0, exp_cnt});
      end
    end
    exp_cnt = CNT_EN ? 4'd15 : 4'd0;
    chk("stall_cnt_sat", {28'd0, bus.stall_cnt_o}, {28'd0, exp_cnt});
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    chk("stall_cnt_flush", {28'd0, bus.stall_cnt_o}, {28'd0, exp_cnt});
    chk("flush_empty", {31'd0, bus.out_valid_o}, 32'd0);

    // Random valid/ready against a queue model of the two entries.
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      chk("rnd_out_valid", {31'd0, bus.out_valid_o}, {31'd0, (q.size() > 0)});
      chk("rnd_in_ready",  {31'd0, bus.in_ready_o},  {31'd0, (q.size() < 2)});
      if (q.size() > 0) chk("rnd_out_data", bus.out_data_o, q[0]);
      if (!CNT_EN) chk("rnd_stall_cnt_zero", {28'd0, bus.stall_cnt_o}, 32'd0);
      r_iv = ($urandom_range(0, 1) == 1);
      r_or = ($urandom_range(0, 3) != 0);
      r_fl = ($urandom_range(0, 63) == 0);
      r_d  = $urandom;
      drive(r_iv, r_d, r_or, r_fl);
      in_f  = r_iv && (q.size() < 2);
      out_f = r_or && (q.size() > 0);
      if (r_fl) begin
        q.delete();
      end else begin
        if (out_f) void'(q.pop_front());
        if (in_f)  q.push_back(r_d);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Two-entry elastic pipeline register with valid/ready handshake on both sides, built on the team's clock-enable/async-reset flip-flops. It sits between adjacent pipeline stages (e.g. IF→ID, ID→EX) and gives full throughput with registered output data and registered upstream ready. A skid entry absorbs the in-flight beat when downstream stalls. A synchronous flush empties the stage for branch/exception recovery.

## Interface
- DW, 32, payload width in bits
- CNTW, 16, stall-counter width in bits
- clk  in  1  clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush; discards all held and incoming data
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  stage can accept a beat
- in_data_i  in  DW  upstream payload
- out_valid_o  out  1  stage holds a beat for downstream
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DW  payload to downstream, always from main register
- stall_cnt_o  out  CNTW  downstream-stall cycle count (see Configuration)

## Operation
- Storage: main_q[DW], skid_q[DW], 2-bit state EMPTY / BUSY (main valid) / FULL (main and skid valid).
- in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- in_ready_o = (state != FULL); out_valid_o = (state != EMPTY); out_data_o = main_q. All are functions of state/registers only; there is no combinational path from any input to any output.
- Transitions when flush_i=0:
  - EMPTY: in_fire → BUSY, main_q<=in_data_i.
  - BUSY: in_fire & out_fire → BUSY, main_q<=in_data_i. in_fire & ~out_fire → FULL, skid_q<=in_data_i. ~in_fire & out_fire → EMPTY. Neither → hold.
  - FULL: out_fire → BUSY, main_q<=skid_q. Otherwise hold. in_fire is impossible in FULL.
- flush_i=1: next state EMPTY from any state, regardless of in_fire/out_fire. A beat handshaken on the input in the flush cycle is dropped. A beat handshaken on the output in the flush cycle counts as delivered.
- Data registers load only on the listed events (clock-enabled). Their contents are don't-care while not valid.
- Order preserved. No beat duplicated or lost except through flush.
- Illegal state encoding (3) → next state EMPTY.

## Timing
- Reset (rst_n low, async): state=EMPTY, main_q=0, skid_q=0, stall count=0. Outputs: out_valid_o=0, in_ready_o=1, out_data_o=0, stall_cnt_o=0.
- Latency: a beat accepted at edge N is on out_data_o with out_valid_o=1 after edge N (1 cycle).
- Throughput: 1 beat/cycle while out_ready_i=1.
- Stall: out_ready_i drops with stage BUSY and in_fire → FULL next cycle, in_ready_o=0. Upstream sees ready low one cycle after downstream stalls.
- Release: out_ready_i=1 in FULL → BUSY; in_ready_o=1 next cycle.
- Reset asserted mid-transfer: both entries lost immediately; no output glitch beyond going to reset values.

## Configuration
- PIPE_SKID_STALL_CNT_EN defined:
  - stall_cnt_o is a CNTW-bit register incremented every cycle with out_valid_o=1 & out_ready_i=0.
  - Saturates at all-ones and does not wrap.
  - Cleared only by rst_n; flush does not clear it.
- Not defined: stall_cnt_o tied to 0 and no counter flops. The port is present in both builds.

## Test plan
- Streaming: out_ready_i=1, send 0x1..0x8 on consecutive cycles → same values appear on out_data_o one cycle later, back-to-back, in_ready_o stays 1.
- Backpressure: stream 0xA,0xB,0xC, hold out_ready_i=0 from the cycle 0xA is output → state FULL, in_ready_o=0, 0xC held upstream. Release → 0xA,0xB,0xC delivered in order, no loss.
- Flush in FULL with in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1. Subsequent beat 0x55 is the next output.
- Async reset asserted while FULL mid-cycle → out_valid_o=0, in_ready_o=1, out_data_o=0 immediately without waiting for a clock edge.
- With PIPE_SKID_STALL_CNT_EN, CNTW=4, stall 20 cycles → stall_cnt_o=15 (saturated). A flush leaves it at 15. Without the macro → stall_cnt_o=0 throughout.
- Random valid/ready (10k cycles) against a scoreboard queue → outputs match inputs in order, and no handshake on the input occurs while in_ready_o=0.
